// File: rtl/countdown_setup_if.sv
// rtl/countdown_setup_if.sv - operator buttons, controller handshake and status bundle for countdown_setup
interface countdown_setup_if;
    // raw operator buttons (asynchronous, active-high)
    logic       btn_inc;
    logic       btn_dec;
    logic       btn_start;
    logic       btn_stop;
    // inputs from the countdown controller
    logic       counting;
    logic       done;
    // outputs towards the countdown controller and status
    logic [7:0] countdown_time;
    logic       start;
    logic       end_timer;
    logic [1:0] state;
    logic       timeout_flag;
    logic       arm_error;

    // master: the side that presses buttons and plays the countdown controller
    modport master (
        output btn_inc, btn_dec, btn_start, btn_stop, counting, done,
        input  countdown_time, start, end_timer, state, timeout_flag, arm_error
    );

    // slave: the setup front end itself
    modport slave (
        input  btn_inc, btn_dec, btn_start, btn_stop, counting, done,
        output countdown_time, start, end_timer, state, timeout_flag, arm_error
    );
endinterface

// File: rtl/countdown_setup.sv
// rtl/countdown_setup.sv - button debounce, countdown length setup and start/abort sequencing
module countdown_setup_debounce #(
    parameter int DEBOUNCE_CYCLES = 2_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_rise
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_level_q;
    logic             r_rise;
    logic [CNT_W-1:0] r_cnt;

    // two-flop synchroniser for the asynchronous raw button
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    // accept a new level only after it has differed for DEBOUNCE_CYCLES consecutive cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else if (r_sync2 == r_level) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_level <= ~r_level;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // registered one-cycle pulse on each rising edge of the debounced level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level_q <= 1'b0;
            r_rise    <= 1'b0;
        end else begin
            r_level_q <= r_level;
            r_rise    <= r_level & ~r_level_q;
        end
    end

    assign o_rise = r_rise;
endmodule

module countdown_setup #(
    parameter int DEBOUNCE_CYCLES = 2_000_000,
    parameter int MIN_TIME        = 1,
    parameter int MAX_TIME        = 15,
    parameter int DEFAULT_TIME    = 10,
    parameter int ARM_TIMEOUT     = 16
) (
    input  logic              clk,
    input  logic              rst,
    countdown_setup_if.slave  bus
);
    typedef enum logic [1:0] {
        S_SETUP    = 2'd0,
        S_ARM      = 2'd1,
        S_RUNNING  = 2'd2,
        S_FINISHED = 2'd3
    } state_t;

    localparam int ARM_W = (ARM_TIMEOUT > 1) ? $clog2(ARM_TIMEOUT) : 1;
    localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM_TIMEOUT - 1);
    localparam logic [3:0] MIN_T = 4'(MIN_TIME);
    localparam logic [3:0] MAX_T = 4'(MAX_TIME);
    localparam logic [3:0] DEF_T = 4'(DEFAULT_TIME);

    // button order inside the vectors: 0=inc, 1=dec, 2=start, 3=stop
    logic [3:0]       w_raw;
    logic [3:0]       w_rise;

    state_t           r_state;
    logic [3:0]       r_time;
    logic             r_start;
    logic             r_end_timer;
    logic             r_timeout_flag;
    logic             r_arm_error;
    logic [ARM_W-1:0] r_arm_cnt;

    state_t           w_state_nxt;
    logic [3:0]       w_time_nxt;
    logic             w_start_nxt;
    logic             w_end_timer_nxt;
    logic             w_timeout_flag_nxt;
    logic             w_arm_error_nxt;
    logic [ARM_W-1:0] w_arm_cnt_nxt;

    assign w_raw = {bus.btn_stop, bus.btn_start, bus.btn_dec, bus.btn_inc};

    for (genvar g = 0; g < 4; g++) begin : g_btn
        countdown_setup_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk    (clk),
            .rst    (rst),
            .i_raw  (w_raw[g]),
            .o_rise (w_rise[g])
        );
    end

    // state and registered outputs; reset drops start/end_timer immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_SETUP;
            r_time         <= DEF_T;
            r_start        <= 1'b0;
            r_end_timer    <= 1'b0;
            r_timeout_flag <= 1'b0;
            r_arm_error    <= 1'b0;
            r_arm_cnt      <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_time         <= w_time_nxt;
            r_start        <= w_start_nxt;
            r_end_timer    <= w_end_timer_nxt;
            r_timeout_flag <= w_timeout_flag_nxt;
            r_arm_error    <= w_arm_error_nxt;
            r_arm_cnt      <= w_arm_cnt_nxt;
        end
    end

    // next state and next output values; pulses default low, levels hold
    always_comb begin
        w_state_nxt        = r_state;
        w_time_nxt         = r_time;
        w_start_nxt        = r_start;
        w_end_timer_nxt    = 1'b0;
        w_timeout_flag_nxt = r_timeout_flag;
        w_arm_error_nxt    = 1'b0;
        w_arm_cnt_nxt      = r_arm_cnt;

        case (r_state)
            S_SETUP: begin
                w_start_nxt        = 1'b0;
                w_timeout_flag_nxt = 1'b0;
                // start takes priority and swallows any inc/dec in the same cycle
                if (w_rise[2]) begin
                    w_state_nxt   = S_ARM;
                    w_start_nxt   = 1'b1;
                    w_arm_cnt_nxt = '0;
                end else if (w_rise[0] && !w_rise[1]) begin
                    if (r_time < MAX_T) begin
                        w_time_nxt = r_time + 4'd1;
                    end
                end else if (w_rise[1] && !w_rise[0]) begin
                    if (r_time > MIN_T) begin
                        w_time_nxt = r_time - 4'd1;
                    end
                end
            end

            S_ARM: begin
                if (bus.counting) begin
                    w_state_nxt = S_RUNNING;
                    w_start_nxt = 1'b0;
                end else if (r_arm_cnt == ARM_LAST) begin
                    w_state_nxt     = S_SETUP;
                    w_start_nxt     = 1'b0;
                    w_arm_error_nxt = 1'b1;
                end else begin
                    w_arm_cnt_nxt = r_arm_cnt + 1'b1;
                end
            end

            S_RUNNING: begin
                // natural expiry beats a coincident operator stop
                if (bus.done) begin
                    w_state_nxt        = S_FINISHED;
                    w_timeout_flag_nxt = 1'b1;
                end else if (w_rise[3]) begin
                    w_state_nxt     = S_SETUP;
                    w_end_timer_nxt = 1'b1;
                end else if (!bus.counting) begin
                    w_state_nxt = S_SETUP;
                end
            end

            S_FINISHED: begin
                // the acknowledging edge is consumed and has no other effect
                if (|w_rise) begin
                    w_state_nxt        = S_SETUP;
                    w_timeout_flag_nxt = 1'b0;
                end
            end

            default: begin
                w_state_nxt = S_SETUP;
            end
        endcase
    end

    assign bus.countdown_time = {4'b0000, r_time};
    assign bus.start          = r_start;
    assign bus.end_timer      = r_end_timer;
    assign bus.state          = r_state;
    assign bus.timeout_flag   = r_timeout_flag;
    assign bus.arm_error      = r_arm_error;
endmodule

// File: doc/countdown_setup.md
Name: countdown_setup

Overview:
- Operator-facing front end for the countdown timer.
- Debounces four raw push-buttons and lets the operator set the countdown length within [MIN_TIME, MAX_TIME].
- Launches the countdown through a start/counting handshake and aborts it via a one-cycle end_timer pulse.
- Sits directly upstream of the countdown controller: drives its start, end_timer and countdown_time inputs, and consumes its counting and done outputs.

Parameters:
- DEBOUNCE_CYCLES, 2_000_000: consecutive stable cycles needed to accept a button level change (20 ms at 100 MHz).
- MIN_TIME, 1: lowest settable countdown value.
- MAX_TIME, 15: highest settable countdown value; must be ≤ 15.
- DEFAULT_TIME, 10: countdown_time after reset.
- ARM_TIMEOUT, 16: cycles allowed in ARM for counting to rise.

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  reset; asynchronous, active-high
- btn_inc  in  1  raw increment button, active-high, asynchronous
- btn_dec  in  1  raw decrement button, active-high, asynchronous
- btn_start  in  1  raw start button, active-high, asynchronous
- btn_stop  in  1  raw stop button, active-high, asynchronous
- counting  in  1  countdown-in-progress flag from the countdown controller
- done  in  1  one-cycle natural-expiry pulse from the countdown controller
- countdown_time  out  8  selected countdown length; bits [7:4] are always 0
- start  out  1  start request (level, held through ARM)
- end_timer  out  1  one-cycle abort pulse
- state  out  2  FSM state: 0=SETUP, 1=ARM, 2=RUNNING, 3=FINISHED
- timeout_flag  out  1  high while in FINISHED
- arm_error  out  1  one-cycle pulse when ARM times out

Behaviour:
Reset values:
- countdown_time=DEFAULT_TIME; start=0, end_timer=0, timeout_flag=0, arm_error=0; state=SETUP.
- All debounced levels are 0; all debounce counters are 0.

Button conditioning (per button, identical):
- 2-FF synchroniser, then a debounce counter.
- The counter increments while the synchronised level differs from the debounced level, and clears when they match.
- When it reaches DEBOUNCE_CYCLES-1, the debounced level flips and the counter clears.
- The edge pulse is the rising edge of the debounced level, one cycle wide.
- Latency from a stable raw press to the edge pulse is DEBOUNCE_CYCLES+3 cycles.
- Glitches shorter than DEBOUNCE_CYCLES produce no edge.

FSM, registered outputs, transitions evaluated on edge pulses:
- SETUP:
  - inc edge: countdown_time+1, saturating at MAX_TIME.
  - dec edge: countdown_time-1, saturating at MIN_TIME.
  - inc and dec edges in the same cycle: no change.
  - start edge: go to ARM with start=1. An inc/dec edge in that same cycle is ignored.
  - stop edge: ignored.
- ARM:
  - start is held 1 and countdown_time is frozen.
  - counting=1 → RUNNING with start=0 on the next cycle.
  - No counting after ARM_TIMEOUT cycles → SETUP, start=0, arm_error pulse.
  - All button edges are ignored.
- RUNNING:
  - countdown_time is frozen; inc/dec/start edges are ignored.
  - done=1 → FINISHED, timeout_flag=1.
  - stop edge (with done=0) → end_timer=1 for exactly one cycle, then SETUP.
  - done and stop edge in the same cycle: done wins, no end_timer.
  - counting falls without done and without our stop → SETUP, no pulses.
- FINISHED:
  - Any inc/dec/start/stop edge → SETUP and clears timeout_flag.
  - That edge is consumed: it does not change the time or arm.
- countdown_time is retained across runs; it only changes in SETUP.
- rst asserted in any state, including mid-ARM or mid-RUNNING, immediately forces all reset values. start and end_timer drop asynchronously.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4.
1. Reset, then 6 inc presses → countdown_time=15 (saturates after 5); then 15 dec presses → 1; state=0 throughout.
2. btn_inc high for 3 cycles only → no change, countdown_time=10. Press held 10 cycles → exactly one increment at 7 cycles after press, value 11.
3. Start press, model raises counting 3 cycles after start rises → start high exactly until counting seen, state 1→2. Model pulses done → state=3, timeout_flag=1. Next inc press → state=0, timeout_flag=0, countdown_time unchanged.
4. RUNNING, stop press → single-cycle end_timer, state=0. Repeat with done coinciding with the stop edge → no end_timer, state=3.
5. Start press with counting tied 0 → start high for 16 cycles, arm_error pulse, state=0. inc during ARM does not change countdown_time.
6. Assert rst mid-RUNNING with start/end_timer activity → all outputs at reset values in the same cycle; countdown_time=10.
